// File: rtl/isp_pkg.sv
// Shared definitions for the ISP AXI4-Stream video blocks.
//   MID(cw)          : mid-scale code of a cw-bit unsigned channel (1 << (cw-1))
//   clamp_u(v, cw)   : saturate a signed value into the unsigned range [0, 2^cw - 1]
//   axis_pix_t       : one RGB888 pixel as carried on the video stream (B in the LSBs)
//   AXIS_PIX_*       : bit offsets of the pixel fields inside a packed pixel
package isp_pkg;

  localparam int AXIS_PIX_CW    = 8;
  localparam int AXIS_PIX_B_LSB = 0;
  localparam int AXIS_PIX_G_LSB = 8;
  localparam int AXIS_PIX_R_LSB = 16;
  localparam int AXIS_PIX_W     = 24;

  typedef struct packed {
    logic [AXIS_PIX_CW-1:0] r;
    logic [AXIS_PIX_CW-1:0] g;
    logic [AXIS_PIX_CW-1:0] b;
  } axis_pix_t;

  function automatic int MID(input int cw);
    return 1 << (cw - 1);
  endfunction

  // Values are 32-bit signed; callers sign-extend their intermediates first.
  function automatic logic [31:0] clamp_u(input logic signed [31:0] value, input int cw);
    logic signed [31:0] hi;
    hi = (32'sd1 <<< cw) - 32'sd1;
    if (value < 32'sd0) return '0;
    if (value > hi) return hi;
    return value;
  endfunction

endpackage

// File: rtl/cba_lane.sv
// One channel of the contrast/brightness datapath: three registers, one per
// pipeline stage, each loading only when the parent asserts its stage enable.
//   S1: x - MID
//   S2: (S1 * gain + round) >>> FRAC     (or S1 unchanged in bypass)
//   S3: clamp(S2 + MID + offset)         (S2 + MID, i.e. x, in bypass)
// Ports:
//   I_clk, I_rst_n        clock, asynchronous active-low reset
//   s1_en/s2_en/s3_en     per-stage load enables from the parent handshake
//   x                     input channel value
//   gain1                 gain copy travelling with the beat held in S1
//   off2                  offset copy travelling with the beat held in S2
//   byp1, byp2            bypass copies for the beats in S1 / S2
//   y                     S3 register, the output channel value
module cba_lane import isp_pkg::*; #(
  parameter int CW     = 8,
  parameter int GAIN_W = 10,
  parameter int FRAC   = 7
) (
  input  logic                I_clk,
  input  logic                I_rst_n,
  input  logic                s1_en,
  input  logic                s2_en,
  input  logic                s3_en,
  input  logic [CW-1:0]       x,
  input  logic [GAIN_W-1:0]   gain1,
  input  logic signed [CW:0]  off2,
  input  logic                byp1,
  input  logic                byp2,
  output logic [CW-1:0]       y
);

  // Wide enough that product, rounding and offset never wrap.
  localparam int TW = CW + GAIN_W + 3;
  localparam logic signed [TW-1:0] MID_T = TW'(MID(CW));
  localparam logic signed [TW-1:0] RND_T = TW'(1 << (FRAC - 1));

  logic signed [TW-1:0] s1_d, s1_q;
  logic signed [TW-1:0] s2_d, s2_q;
  logic [CW-1:0]        y_d, y_q;
  logic signed [TW-1:0] prod;
  logic signed [TW-1:0] off_ext;
  logic signed [TW-1:0] sum;

  always_comb begin
    prod    = s1_q * $signed({{(TW-GAIN_W){1'b0}}, gain1});
    off_ext = byp2 ? '0 : {{(TW-CW-1){off2[CW]}}, off2};
    // In bypass S2 still holds x - MID, so adding MID back restores x exactly.
    sum     = s2_q + MID_T + off_ext;

    s1_d = s1_q;
    s2_d = s2_q;
    y_d  = y_q;
    if (s1_en) s1_d = $signed({{(TW-CW){1'b0}}, x}) - MID_T;
    if (s2_en) s2_d = byp1 ? s1_q : ((prod + RND_T) >>> FRAC);
    if (s3_en) y_d  = CW'(clamp_u({{(32-TW){sum[TW-1]}}, sum}, CW));
  end

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      s1_q <= '0;
      s2_q <= '0;
      y_q  <= '0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      y_q  <= y_d;
    end
  end

  assign y = y_q;

endmodule

// File: rtl/contrast_bright_adj.sv
// Per-pixel contrast + brightness stage for the AXI4-Stream RGB video chain.
// PPC pixels of NCH channels per beat, CW bits per channel, channel c of pixel p
// at bit (p*NCH + c)*CW. Each channel goes through a cba_lane; this module owns
// the stage valids, the tlast/tuser pipes, the gain/offset/bypass shadows and
// the SOF counter.
// Ports:
//   I_clk, I_rst_n            clock, asynchronous active-low reset
//   I_gain/I_offset/I_bypass  run-time controls, sampled only on an accepted SOF beat
//   I_tdata/I_tvalid/I_tready/I_tlast/I_tuser   input stream (tuser = SOF)
//   O_tdata/O_tvalid/O_tready/O_tlast/O_tuser   output stream
//   O_frame_cnt               number of accepted SOF beats, wrapping at 16 bits
//
// Handshake: a beat transfers on any edge where valid & ready are both high.
// Stage k loads (data, sidebands, control copies) when it is empty or stage
// k+1 loads in the same cycle; S3 empties when O_tready is high. I_tready is
// therefore combinational from O_tready. A stalled S3 keeps its registers, so
// O_tdata/O_tlast/O_tuser stay stable while O_tvalid & !O_tready.
module contrast_bright_adj import isp_pkg::*; #(
  parameter int PPC      = 4,
  parameter int NCH      = 3,
  parameter int CW       = 8,
  parameter int GAIN_W   = 10,
  parameter int FRAC     = 7,
  parameter int GAIN_RST = 128
) (
  input  logic                    I_clk,
  input  logic                    I_rst_n,
  input  logic [GAIN_W-1:0]       I_gain,
  input  logic signed [CW:0]      I_offset,
  input  logic                    I_bypass,
  input  logic [PPC*NCH*CW-1:0]   I_tdata,
  input  logic                    I_tvalid,
  output logic                    I_tready,
  input  logic                    I_tlast,
  input  logic                    I_tuser,
  output logic [PPC*NCH*CW-1:0]   O_tdata,
  output logic                    O_tvalid,
  input  logic                    O_tready,
  output logic                    O_tlast,
  output logic                    O_tuser,
  output logic [15:0]             O_frame_cnt
);

  localparam int NL = PPC * NCH;

  logic en1, en2, en3;
  logic acc, sof_acc;

  logic v1_d, v1_q, v2_d, v2_q, v3_d, v3_q;
  // Sidebands per stage as {tlast, tuser}.
  logic [1:0] sb1_d, sb1_q, sb2_d, sb2_q, sb3_d, sb3_q;

  // Active shadows: what a non-SOF beat entering now will use.
  logic [GAIN_W-1:0]  act_gain_d, act_gain_q;
  logic signed [CW:0] act_off_d, act_off_q;
  logic               act_byp_d, act_byp_q;

  // Per-stage copies of the controls, kept only as far as they are consumed.
  logic [GAIN_W-1:0]  gain1_d, gain1_q;
  logic signed [CW:0] off1_d, off1_q, off2_d, off2_q;
  logic               byp1_d, byp1_q, byp2_d, byp2_q;

  logic [15:0] frame_cnt_d, frame_cnt_q;

  logic [GAIN_W-1:0]  eff_gain;
  logic signed [CW:0] eff_off;
  logic               eff_byp;

  always_comb begin
    en3     = !v3_q || O_tready;
    en2     = !v2_q || en3;
    en1     = !v1_q || en2;
    acc     = I_tvalid && en1;
    sof_acc = acc && I_tuser;

    // The SOF beat itself already uses the newly captured controls.
    eff_gain = sof_acc ? I_gain   : act_gain_q;
    eff_off  = sof_acc ? I_offset : act_off_q;
    eff_byp  = sof_acc ? I_bypass : act_byp_q;

    act_gain_d  = eff_gain;
    act_off_d   = eff_off;
    act_byp_d   = eff_byp;
    frame_cnt_d = sof_acc ? frame_cnt_q + 16'd1 : frame_cnt_q;

    v1_d = v1_q;  sb1_d = sb1_q;  gain1_d = gain1_q;  off1_d = off1_q;  byp1_d = byp1_q;
    v2_d = v2_q;  sb2_d = sb2_q;  off2_d  = off2_q;   byp2_d = byp2_q;
    v3_d = v3_q;  sb3_d = sb3_q;

    if (en1) begin
      v1_d    = I_tvalid;
      sb1_d   = {I_tlast, I_tuser};
      gain1_d = eff_gain;
      off1_d  = eff_off;
      byp1_d  = eff_byp;
    end
    if (en2) begin
      v2_d   = v1_q;
      sb2_d  = sb1_q;
      off2_d = off1_q;
      byp2_d = byp1_q;
    end
    if (en3) begin
      v3_d  = v2_q;
      sb3_d = sb2_q;
    end
  end

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      v3_q        <= 1'b0;
      sb1_q       <= '0;
      sb2_q       <= '0;
      sb3_q       <= '0;
      act_gain_q  <= GAIN_W'(GAIN_RST);
      act_off_q   <= '0;
      act_byp_q   <= 1'b0;
      gain1_q     <= GAIN_W'(GAIN_RST);
      off1_q      <= '0;
      off2_q      <= '0;
      byp1_q      <= 1'b0;
      byp2_q      <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      v1_q        <= v1_d;
      v2_q        <= v2_d;
      v3_q        <= v3_d;
      sb1_q       <= sb1_d;
      sb2_q       <= sb2_d;
      sb3_q       <= sb3_d;
      act_gain_q  <= act_gain_d;
      act_off_q   <= act_off_d;
      act_byp_q   <= act_byp_d;
      gain1_q     <= gain1_d;
      off1_q      <= off1_d;
      off2_q      <= off2_d;
      byp1_q      <= byp1_d;
      byp2_q      <= byp2_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  for (genvar l = 0; l < NL; l++) begin : g_lane
    cba_lane #(
      .CW     (CW),
      .GAIN_W (GAIN_W),
      .FRAC   (FRAC)
    ) u_lane (
      .I_clk   (I_clk),
      .I_rst_n (I_rst_n),
      .s1_en   (en1),
      .s2_en   (en2),
      .s3_en   (en3),
      .x       (I_tdata[l*CW +: CW]),
      .gain1   (gain1_q),
      .off2    (off2_q),
      .byp1    (byp1_q),
      .byp2    (byp2_q),
      .y       (O_tdata[l*CW +: CW])
    );
  end

  assign I_tready    = en1;
  assign O_tvalid    = v3_q;
  assign O_tlast     = sb3_q[1];
  assign O_tuser     = sb3_q[0];
  assign O_frame_cnt = frame_cnt_q;

endmodule
